// File: rtl/sr_ff_driver_pkg.sv
// Shared types and constants for the SR flip-flop driver.
package sr_drv_pkg;

  localparam int unsigned CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    CMD_HOLD   = 2'b00,
    CMD_RESET  = 2'b01,
    CMD_SET    = 2'b10,
    CMD_TOGGLE = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_CHECK = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/sr_ff_driver_if.sv
// Command/response and flip-flop drive/readback bundle for sr_ff_driver.
interface sr_ff_driver_if;
  import sr_drv_pkg::*;

  logic cmd_valid;
  cmd_e cmd;
  logic cmd_ready;
  logic S;
  logic R;
  logic Q;
  logic Qbar;
  logic rsp_valid;
  logic rsp_err;

  // Requester side: issues commands and presents the flip-flop readback.
  modport master (
    output cmd_valid, cmd, Q, Qbar,
    input  cmd_ready, S, R, rsp_valid, rsp_err
  );

  // Driver side.
  modport slave (
    input  cmd_valid, cmd, Q, Qbar,
    output cmd_ready, S, R, rsp_valid, rsp_err
  );

endinterface

// File: rtl/sr_ff_driver.sv
// Pulses S/R of an external SR flip-flop per command and reports completion.
// Define SR_DRV_READBACK_EN to verify Q/Qbar readback after each pulse.
module sr_ff_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input logic           clk,
  input logic           rst,
  sr_ff_driver_if.slave bus
);

  localparam cnt_t PULSE_LAST = cnt_t'(PULSE_CYCLES);

  state_e r_state;
  cnt_t   r_pulse_cnt;
  logic   r_s;
  logic   r_r;
  logic   r_cmd_ready;
  logic   r_rsp_valid;
  logic   w_tgt_set;

  // TOGGLE resolves against the readback sampled at acceptance.
  always_comb begin
    w_tgt_set = (bus.cmd == CMD_SET) || ((bus.cmd == CMD_TOGGLE) && !bus.Q);
  end

`ifdef SR_DRV_READBACK_EN
  localparam cnt_t TO_LAST = cnt_t'(TIMEOUT_CYCLES - 1);

  cnt_t r_to_cnt;
  logic r_exp_q;
  logic r_rsp_err;
  logic w_rb_bad;
  logic w_rb_ok;

  always_comb begin
    w_rb_bad = (bus.Q == bus.Qbar);
    w_rb_ok  = (bus.Q == r_exp_q) && (bus.Qbar == !r_exp_q);
  end

  assign bus.rsp_err = r_rsp_err;
`else
  localparam cnt_t w_unused_timeout = cnt_t'(TIMEOUT_CYCLES);
  logic w_unused_qbar;
  assign w_unused_qbar = bus.Qbar;
  assign bus.rsp_err   = 1'b0;
`endif

  // Control FSM; S and R are only ever set from a one-hot target.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pulse_cnt <= '0;
      r_s         <= 1'b0;
      r_r         <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
`ifdef SR_DRV_READBACK_EN
      r_to_cnt    <= '0;
      r_exp_q     <= 1'b0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
`ifdef SR_DRV_READBACK_EN
      r_rsp_err   <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (bus.cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            if (bus.cmd == CMD_HOLD) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state     <= ST_PULSE;
              r_s         <= w_tgt_set;
              r_r         <= !w_tgt_set;
              r_pulse_cnt <= cnt_t'(1);
`ifdef SR_DRV_READBACK_EN
              r_exp_q     <= w_tgt_set;
`endif
            end
          end
        end

        ST_PULSE: begin
          if (r_pulse_cnt >= PULSE_LAST) begin
            r_s <= 1'b0;
            r_r <= 1'b0;
`ifdef SR_DRV_READBACK_EN
            r_state  <= ST_CHECK;
            r_to_cnt <= '0;
`else
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
`endif
          end else begin
            r_pulse_cnt <= sat_inc(r_pulse_cnt);
          end
        end

        ST_CHECK: begin
`ifdef SR_DRV_READBACK_EN
          // Forbidden/invalid readback wins over both pass and timeout.
          if (w_rb_bad) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
          end else if (w_rb_ok) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
          end else if (r_to_cnt >= TO_LAST) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
          end else begin
            r_to_cnt <= sat_inc(r_to_cnt);
          end
`else
          r_state <= ST_IDLE;
`endif
        end

        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end

        default: begin
          r_state <= ST_IDLE;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.S         = r_s;
  assign bus.R         = r_r;
  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;

endmodule

// File: doc/sr_ff_driver.md
SR_FF_DRIVER -- requirements
Module: sr_ff_driver

Interface
REQ-001 Parameter PULSE_CYCLES, default 2, number of cycles S or R is held high per command; legal range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 8, maximum number of CHECK cycles spent waiting for readback; legal range 1..255.
REQ-003 Port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port cmd_valid, input, 1, command offered.
REQ-006 Port cmd, input, 2, command code: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
REQ-007 Port cmd_ready, output, 1, driver can accept a command.
REQ-008 Port S, output, 1, set drive to the SR flip-flop.
REQ-009 Port R, output, 1, reset drive to the SR flip-flop.
REQ-010 Port Q, input, 1, flip-flop output readback.
REQ-011 Port Qbar, input, 1, complementary flip-flop output readback.
REQ-012 Port rsp_valid, output, 1, single-cycle completion pulse.
REQ-013 Port rsp_err, output, 1, completion status; valid only while rsp_valid is high.

Function
REQ-014 S and R shall be registered outputs and shall never be high in the same cycle, including during reset and reset exit.
REQ-015 States shall be IDLE, PULSE, CHECK and RESP; cmd_ready shall be high only in IDLE.
REQ-016 A command is accepted on a clock edge where cmd_valid and cmd_ready are both high; cmd shall be captured at that edge.
REQ-017 TOGGLE resolves at acceptance: the target is SET if the sampled Q=0, and RESET if Q=1.
REQ-018 SET or RESET acceptance: IDLE->PULSE; S (SET) or R (RESET) shall be high for exactly PULSE_CYCLES cycles, starting the cycle after acceptance.
REQ-019 After PULSE: PULSE->CHECK with S=R=0; expected value is Q=1 for SET and Q=0 for RESET.
REQ-020 CHECK passes when Q equals the expected value and Qbar equals its inverse; the block then moves to RESP with rsp_err=0.
REQ-021 If CHECK has not passed after TIMEOUT_CYCLES cycles, the block shall move to RESP with rsp_err=1.
REQ-022 Q equal to Qbar in any CHECK cycle shall go to RESP immediately with rsp_err=1 (invalid or forbidden output state).
REQ-023 HOLD acceptance: IDLE->RESP with no S/R activity and rsp_err=0.
REQ-024 RESP shall last one cycle with rsp_valid=1, then return to IDLE; the earliest next acceptance is the cycle after RESP.
REQ-025 Minimum SET latency, acceptance edge to rsp_valid, is PULSE_CYCLES+2 cycles when readback matches on the first CHECK cycle.
REQ-026 Pulse and timeout counters shall be 8 bits and shall saturate rather than wrap.
REQ-027 cmd_valid arriving outside IDLE shall be ignored, with no buffering.

Reset
REQ-028 While rst is high: state=IDLE, S=0, R=0, rsp_valid=0, rsp_err=0, counters=0, cmd_ready=0.
REQ-029 cmd_ready shall be 1 from the first cycle after rst deasserts.
REQ-030 Reset asserted mid-PULSE or mid-CHECK shall abort the operation, drop S/R on the next edge, and emit no rsp_valid.

Configuration
REQ-031 Macro SR_DRV_READBACK_EN: when defined, CHECK behaves per REQ-019..022.
REQ-032 When SR_DRV_READBACK_EN is undefined, CHECK shall be bypassed (PULSE->RESP), rsp_err shall be tied 0, Q is used only for TOGGLE, and Qbar is unused.

Structure
REQ-033 Shared package sr_drv_pkg shall hold the cmd code constants, the state enumeration, and the counter width constant (8).
REQ-034 The block is a single module; no sub-module is required.

Verification
REQ-035 Reset, then SET with Q/Qbar model following S/R -> S high cycles 1..2, rsp_valid at cycle 4, rsp_err=0.
REQ-036 RESET then TOGGLE from Q=0 -> R pulse then S pulse, two rsp_valid pulses each with rsp_err=0, S and R never high together.
REQ-037 SET with Q stuck at 0 and Qbar=1 -> rsp_valid exactly 8 CHECK cycles after PULSE, rsp_err=1.
REQ-038 SET with Q=Qbar=1 during CHECK -> rsp_valid on the next cycle, rsp_err=1.
REQ-039 HOLD -> rsp_valid the cycle after acceptance, S=R=0 throughout; cmd_valid held high in RESP is not accepted until IDLE.
REQ-040 rst asserted in the 2nd PULSE cycle -> S=0 on the next edge, no rsp_valid; with macro undefined, SET gives rsp_valid at cycle 3 and rsp_err=0.
